pixel_frame_capture: RTL and testbench
======================================

# pixel_frame_capture

Stream-to-memory frame writer for the image path. It accepts a valid/ready pixel stream, one pixel word per beat with a start-of-frame flag, and writes exactly DEPTH words into an internal frame buffer. It then holds the frame for random-access readback. It is the writer end of the image-memory interface whose reader sweeps the frame buffer and applies the brightness offset.

## Interface
- DATA_W, 33: pixel word width (matches image.hex word format)
- DEPTH, 2100: words per frame
- ADDR_W, 12: address width; must satisfy 2**ADDR_W >= DEPTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  block can accept a word
- s_data  in  DATA_W  pixel word
- s_sof  in  1  qualifies s_data as the first word of a frame
- release  in  1  one-cycle pulse: frame consumed, return to IDLE
- rd_en  in  1  readback request
- rd_addr  in  ADDR_W  readback address
- rd_data  out  DATA_W  readback word, registered
- frame_done  out  1  level: complete frame held in buffer
- wr_count  out  ADDR_W+1  words written in current frame
- sof_err  out  1  one-cycle pulse: SOF arrived mid-frame
- drop_count  out  16  saturating count of words discarded in IDLE

## Operation
- Handshake: a beat transfers on a rising edge with s_valid && s_ready. s_data and s_sof must hold while s_valid && !s_ready.
- States: IDLE, CAPTURE, DONE. s_ready = (state != DONE), decoded from registered state only, so there is no combinational path from s_valid.
- IDLE:
  - beat with s_sof=1: write mem[0], wr_count<=1, go to CAPTURE. If DEPTH==1, go directly to DONE.
  - beat with s_sof=0: word dropped, drop_count++ (saturates at 16'hFFFF).
- CAPTURE:
  - beat with s_sof=0: write mem[wr_count], wr_count++.
  - beat whose wr_count == DEPTH-1 before increment: write, then go to DONE.
  - beat with s_sof=1: pulse sof_err, restart the frame by writing mem[0] and setting wr_count<=1. No drop is counted.
- DONE: frame_done=1, s_ready=0, wr_count holds DEPTH. release returns to IDLE and clears wr_count to 0.
- release in IDLE or CAPTURE is ignored.
- release and s_valid in the same DONE cycle: release wins and the beat is not accepted (s_ready was 0). Acceptance starts at the earliest on the next cycle.
- Readback:
  - rd_en samples mem[rd_addr] into rd_data. rd_data holds its value when rd_en=0.
  - rd_addr >= DEPTH returns 0.
  - Readback is legal in any state. In CAPTURE, addresses >= wr_count return stale data; this is permitted.
- Same-cycle read and write to the same address: rd_data returns the old contents (read-before-write).

## Timing
- Write latency: the word is in memory at the handshake edge and readable with rd_en on the next cycle.
- frame_done rises in the cycle after the last beat's edge. s_ready falls in the same cycle.
- rd_data latency: 1 cycle from rd_en.
- sof_err: high for exactly the cycle after the offending beat.
- Reset (asynchronous, any time including mid-frame) drives these values:
  - state=IDLE, s_ready=1
  - wr_count=0, drop_count=0
  - frame_done=0, sof_err=0
  - rd_data=0
- Reset does not clear memory contents, which are undefined after power-up.

## Structure
- Shared package img_pkg holds:
  - PIX_W=33, FRAME_DEPTH=2100, FRAME_ADDR_W=12
  - the state enum cap_state_t {IDLE, CAPTURE, DONE}
- One sub-module, frame_ram: a single-clock simple dual-port RAM (1 write port, 1 registered read port, read-before-write), DATA_W x DEPTH, with no reset on the array.
- The FSM, counters and the handshake stay in pixel_frame_capture.

## Test plan
- Bench uses DEPTH=8. Stream words 0x00..0x07, SOF on the first, s_valid held high. Required response:
  - frame_done rises the cycle after the 8th beat; wr_count=8, s_ready=0.
  - Reading addresses 0..7 returns 0x00..0x07, each one cycle after rd_en.
- 3 words without SOF in IDLE, then a full frame: drop_count=3, and the frame captured from address 0.
- SOF at beat 5 of a frame. Required response:
  - sof_err pulses once.
  - Address 0 holds the new SOF word.
  - frame_done only after 8 beats counted from the second SOF.
- In DONE, pulse release together with s_valid=1 and SOF:
  - no beat is accepted that cycle;
  - the next cycle s_ready=1, the beat is accepted and wr_count=1.
- Assert rst_n=0 after beat 4, mid-frame. Required response:
  - all outputs at their reset values immediately (asynchronous);
  - after release of reset, a new 8-word frame completes normally.
- rd_en with rd_addr=9 returns 0. A same-cycle write and read of address 2 during CAPTURE returns the old value of address 2.

Source files
------------

// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image-memory path: pixel word width, frame depth,
// frame address width and the capture FSM state type used by the writer.
// -----------------------------------------------------------------------------
package img_pkg;

   localparam int PIX_W        = 33;    // matches the image.hex word format
   localparam int FRAME_DEPTH  = 2100;  // words per frame
   localparam int FRAME_ADDR_W = 12;    // 2**FRAME_ADDR_W >= FRAME_DEPTH

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } cap_state_t;

endpackage

// File: rtl/frame_ram.sv
// -----------------------------------------------------------------------------
// frame_ram
// Single-clock simple dual-port RAM, DATA_W x DEPTH: one write port and one
// registered read port with read-before-write behaviour. Reads at addresses
// >= DEPTH return zero.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata   write port
//   re, raddr          read request and address
//   rdata              registered read word, holds while re=0
// -----------------------------------------------------------------------------
module frame_ram #(
   parameter int DATA_W = 33,
   parameter int DEPTH  = 2100,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto block RAM; only the
   // read register below is reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // NOTE: non-blocking assignments in both processes give read-before-write:
   // a same-edge read of the written address still sees the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         if ({1'b0, raddr} < DEPTH_L) begin
            rdata <= mem[raddr];
         end else begin
            rdata <= '0;
         end
      end
   end

endmodule

// File: rtl/pixel_frame_capture.sv
// -----------------------------------------------------------------------------
// pixel_frame_capture
// Stream-to-memory frame writer. Accepts a valid/ready pixel stream with a
// start-of-frame flag, writes exactly DEPTH words into frame_ram, then holds
// the frame for random-access readback until frame_release.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   s_valid/s_ready input stream handshake (s_ready from registered state)
//   s_data, s_sof   pixel word and start-of-frame qualifier
//   frame_release   one-cycle pulse: frame consumed, return to IDLE.
//                   ('release' is a reserved word in SystemVerilog.)
//   rd_en, rd_addr  readback request
//   rd_data         registered readback word (0 for rd_addr >= DEPTH)
//   frame_done      level: complete frame held in buffer
//   wr_count        words written in the current frame
//   sof_err         one-cycle pulse: SOF arrived mid-frame
//   drop_count      saturating count of words discarded in IDLE
// -----------------------------------------------------------------------------
module pixel_frame_capture
   import img_pkg::*;
#(
   parameter int DATA_W = PIX_W,
   parameter int DEPTH  = FRAME_DEPTH,
   parameter int ADDR_W = FRAME_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sof,
   input  logic              frame_release,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              frame_done,
   output logic [ADDR_W:0]   wr_count,
   output logic              sof_err,
   output logic [15:0]       drop_count
);

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   // A one-word frame completes on its SOF beat.
   localparam cap_state_t AFTER_SOF = (DEPTH == 1) ? DONE : CAPTURE;

   cap_state_t        state;
   logic              beat;
   logic              we;
   logic [ADDR_W-1:0] waddr;

   assign s_ready    = (state != DONE);
   assign frame_done = (state == DONE);
   assign beat       = s_valid && s_ready;

   // Every accepted beat is written except a non-SOF word in IDLE (dropped).
   // An SOF beat always lands at address 0, restarting any frame in progress.
   assign we    = beat && ((state != IDLE) || s_sof);
   assign waddr = s_sof ? '0 : wr_count[ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_count   <= '0;
         drop_count <= '0;
         sof_err    <= 1'b0;
      end else begin
         sof_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (beat) begin
                  if (s_sof) begin
                     wr_count <= (ADDR_W + 1)'(1);
                     state    <= AFTER_SOF;
                  end else if (drop_count != 16'hFFFF) begin
                     drop_count <= drop_count + 16'd1;
                  end
               end
            end
            CAPTURE: begin
               if (beat) begin
                  if (s_sof) begin
                     sof_err  <= 1'b1;
                     wr_count <= (ADDR_W + 1)'(1);
                     state    <= AFTER_SOF;
                  end else begin
                     wr_count <= wr_count + (ADDR_W + 1)'(1);
                     if (wr_count == LAST_IDX) begin
                        state <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               wr_count <= FULL_CNT;
               if (frame_release) begin
                  wr_count <= '0;
                  state    <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               wr_count <= '0;
            end
         endcase
      end
   end

   frame_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_frame_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (waddr),
      .wdata (s_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_pixel_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_pixel_frame_capture
// Self-checking bench for pixel_frame_capture with DEPTH=8. A behavioural
// model tracks the frame rules (in-frame flag, word count, buffer contents,
// drop count) and every DUT output is compared against it.
// -----------------------------------------------------------------------------
module tb_pixel_frame_capture;

   localparam int DATA_W = 33;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_sof;
   logic              frame_release;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              frame_done;
   logic [ADDR_W:0]   wr_count;
   logic              sof_err;
   logic [15:0]       drop_count;

   pixel_frame_capture #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_sof         (s_sof),
      .frame_release (frame_release),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .frame_done    (frame_done),
      .wr_count      (wr_count),
      .sof_err       (sof_err),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_in_frame = 0;
   bit                m_done     = 0;
   int                m_count    = 0;
   int                m_drop     = 0;
   bit                m_sof_err  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [63:0] w;
      w = {$urandom, $urandom};
      return w[DATA_W-1:0];
   endfunction

   // Applies the frame rules to one accepted beat.
   function automatic void model_accept(input logic [DATA_W-1:0] data, input bit sof);
      m_sof_err = 0;
      if (!m_in_frame) begin
         if (sof) begin
            m_mem[0]   = data;
            m_count    = 1;
            m_in_frame = 1;
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end else if (sof) begin
         m_sof_err = 1;
         m_mem[0]  = data;
         m_count   = 1;
      end else begin
         m_mem[m_count] = data;
         m_count++;
      end
      if (m_in_frame && m_count == DEPTH) begin
         m_done     = 1;
         m_in_frame = 0;
      end
   endfunction

   task automatic check_status(input string tag);
      check({tag, ".wr_count"},   64'(wr_count),   64'(m_count));
      check({tag, ".frame_done"}, 64'(frame_done), 64'(m_done));
      check({tag, ".s_ready"},    64'(s_ready),    64'(!m_done));
      check({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
      check({tag, ".sof_err"},    64'(sof_err),    64'(m_sof_err));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a beat and waits (bounded) until it is accepted; s_valid stays high.
   task automatic send_beat(input logic [DATA_W-1:0] data, input bit sof, input string tag);
      bit taken = 0;
      s_valid = 1'b1;
      s_data  = data;
      s_sof   = sof;
      for (int i = 0; i < 20 && !taken; i++) begin
         if (s_ready) begin
            tick();
            model_accept(data, sof);
            check_status(tag);
            taken = 1;
         end else begin
            tick();
            m_sof_err = 0;
         end
      end
      if (!taken) check({tag, ".accept_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic stop_stream();
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] addr, input string tag);
      logic [DATA_W-1:0] exp;
      exp     = (int'(addr) < DEPTH) ? m_mem[addr] : '0;
      rd_en   = 1'b1;
      rd_addr = addr;
      tick();
      m_sof_err = 0;
      rd_en   = 1'b0;
      check(tag, 64'(rd_data), 64'(exp));
   endtask

   task automatic do_release(input string tag);
      frame_release = 1'b1;
      tick();
      frame_release = 1'b0;
      m_sof_err = 0;
      if (m_done) begin
         m_done  = 0;
         m_count = 0;
      end
      check_status(tag);
   endtask

   initial begin
      logic [DATA_W-1:0] old2;
      int guard;

      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
      frame_release = 1'b0; rd_en = 1'b0; rd_addr = '0;
      #12;
      check_status("reset");
      check("reset.rd_data", 64'(rd_data), 64'd0);
      rst_n = 1'b1;
      tick();

      // Frame of 0..7, s_valid held high.
      for (int i = 0; i < DEPTH; i++) send_beat(DATA_W'(i), i == 0, "frame1");
      stop_stream();
      tick();
      check_status("frame1.hold");
      for (int i = 0; i < DEPTH; i++) do_read(ADDR_W'(i), "frame1.read");
      do_read(ADDR_W'(7), "read7");
      tick();
      check("rd_hold", 64'(rd_data), 64'h7);
      do_read(ADDR_W'(9), "read_oob");

      // Drops in IDLE, then a frame.
      do_release("release1");
      for (int i = 0; i < 3; i++) send_beat(DATA_W'(32'hA0 + i), 0, "drop");
      for (int i = 0; i < DEPTH; i++) send_beat(DATA_W'(32'h10 + i), i == 0, "frame2");
      stop_stream();
      for (int i = 0; i < DEPTH; i++) do_read(ADDR_W'(i), "frame2.read");

      // SOF at beat 5, plus same-cycle write/read of address 2 in CAPTURE.
      do_release("release2");
      send_beat(DATA_W'(32'h30), 1, "sof5");
      send_beat(DATA_W'(32'h31), 0, "sof5");
      old2    = m_mem[2];
      s_data  = DATA_W'(32'h32);
      s_sof   = 1'b0;
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(2);
      check("rbw.ready", 64'(s_ready), 64'd1);
      tick();
      rd_en = 1'b0;
      model_accept(DATA_W'(32'h32), 0);
      check("rbw.old_value", 64'(rd_data), 64'(old2));
      check_status("rbw");
      send_beat(DATA_W'(32'h33), 0, "sof5");
      send_beat(DATA_W'(32'h40), 1, "sof5.second");
      for (int i = 1; i < DEPTH; i++) send_beat(DATA_W'(32'h40 + i), 0, "sof5.after");
      stop_stream();
      tick();
      check("sof5.sof_err_once", 64'(sof_err), 64'd0);
      for (int i = 0; i < DEPTH; i++) do_read(ADDR_W'(i), "sof5.read");

      // Release together with a SOF beat in DONE.
      frame_release = 1'b1;
      s_valid = 1'b1; s_sof = 1'b1; s_data = DATA_W'(32'h55);
      tick();
      frame_release = 1'b0;
      m_done = 0; m_count = 0; m_sof_err = 0;
      check_status("rel_beat.same");
      tick();
      model_accept(DATA_W'(32'h55), 1);
      check_status("rel_beat.next");
      for (int i = 1; i < DEPTH; i++) send_beat(DATA_W'(32'h50 + i), 0, "rel_frame");
      stop_stream();
      do_read(ADDR_W'(0), "rel_frame.read0");

      // Asynchronous reset mid-frame.
      do_release("release3");
      for (int i = 0; i < 4; i++) send_beat(DATA_W'(32'h60 + i), i == 0, "pre_rst");
      stop_stream();
      do_read(ADDR_W'(7), "pre_rst.read");
      #2;
      rst_n = 1'b0;
      #1;
      m_in_frame = 0; m_done = 0; m_count = 0; m_drop = 0; m_sof_err = 0;
      check_status("async_rst");
      check("async_rst.rd_data", 64'(rd_data), 64'd0);
      #3;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < DEPTH; i++) send_beat(DATA_W'(32'h70 + i), i == 0, "post_rst");
      stop_stream();
      for (int i = 0; i < DEPTH; i++) do_read(ADDR_W'(i), "post_rst.read");
      do_release("release4");

      // Randomized frames: drops, gaps, mid-frame SOFs, ignored releases, reads.
      for (int f = 0; f < 6; f++) begin
         for (int d = $urandom_range(0, 2); d > 0; d--) send_beat(rand_word(), 0, "rnd.drop");
         send_beat(rand_word(), 1, "rnd.sof");
         guard = 0;
         while (!m_done && guard < 200) begin
            guard++;
            if ($urandom_range(0, 3) == 0) begin
               stop_stream();
               repeat ($urandom_range(1, 2)) begin
                  tick();
                  m_sof_err = 0;
               end
            end
            if ($urandom_range(0, 9) == 0) begin
               stop_stream();
               do_release("rnd.release_ignored");
            end
            if ($urandom_range(0, 4) == 0) begin
               stop_stream();
               do_read(ADDR_W'($urandom_range(0, 15)), "rnd.read_capture");
            end
            send_beat(rand_word(), $urandom_range(0, 9) == 0, "rnd.beat");
         end
         stop_stream();
         if (!m_done) check("rnd.frame_timeout", 64'd0, 64'd1);
         for (int i = 0; i < 10; i++) do_read(ADDR_W'($urandom_range(0, 15)), "rnd.read_done");
         do_release("rnd.release");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
